// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared definitions for the CPU memory arbiter: FSM state encoding,
// access owner ids, default bus widths and a small saturating helper.
package cpu_mem_arbiter_pkg;

    localparam int ARB_AW_DEF         = 32;
    localparam int ARB_DW_DEF         = 32;
    localparam int ARB_STARVE_LIM_DEF = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_t;

    // Increment v by one but never past lim.
    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

endpackage

// File: rtl/cpu_mem_arbiter_prio_pick.sv
// Arbitration policy for the CPU memory arbiter: combinational winner
// selection (LS over IF) plus the starvation counter that forces a fetch
// through after STARVE_LIM consecutive LS wins against a pending fetch.
// The counter only moves while the arbiter sits in IDLE, i.e. at the
// moment a winner is actually committed.
module cpu_mem_arbiter_prio_pick
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIM = ARB_STARVE_LIM_DEF
)(
    input  logic       clk,
    input  logic       rest,
    input  logic       idle,
    input  logic       if_req,
    input  logic       ls_req,
    output arb_owner_t winner
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic [3:0] starve_cnt_reg;
    logic       if_forced;

    assign if_forced = if_req && (starve_cnt_reg == LIM);

    // Winner select: LS unless it is absent or fetch has waited long enough.
    always_comb begin
        winner = OWN_IF;
        if (ls_req && !if_forced) begin
            winner = OWN_LS;
        end
    end

    // Starvation counter: counts LS wins taken while a fetch was waiting.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            starve_cnt_reg <= 4'd0;
        end else if (idle) begin
            if (!if_req || (winner == OWN_IF)) begin
                starve_cnt_reg <= 4'd0;
            end else begin
                starve_cnt_reg <= sat_inc(starve_cnt_reg, LIM);
            end
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// CPU memory arbiter: shares one single-port synchronous memory between the
// instruction-fetch port (read-only) and the load/store port. One access is
// in flight at a time: IDLE (pick + latch) -> ISSUE (mem strobe, gnt) ->
// RESP (rvalid). Read data is forwarded straight from the memory during the
// RESP cycle and held in a per-port register afterwards.
// Optional: define ARB_PERF_CNT_EN to add per-port wait-cycle counters.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int AW         = ARB_AW_DEF,
    parameter int DW         = ARB_DW_DEF,
    parameter int STARVE_LIM = ARB_STARVE_LIM_DEF
)(
    input  logic            clk,
    input  logic            rest,
    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [DW-1:0]   if_rdata_o,
    input  logic            ls_req_i,
    input  logic            ls_we_i,
    input  logic [AW-1:0]   ls_addr_i,
    input  logic [DW-1:0]   ls_wdata_i,
    input  logic [DW/8-1:0] ls_be_i,
    output logic            ls_gnt_o,
    output logic            ls_rvalid_o,
    output logic [DW-1:0]   ls_rdata_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic [DW/8-1:0] mem_be_o,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic            stall_o
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]     if_wait_cnt_o,
    output logic [31:0]     ls_wait_cnt_o
`endif
);

    arb_state_t    state_reg;
    arb_owner_t    owner_reg;
    arb_owner_t    winner;
    logic          cmd_we_reg;
    logic [DW-1:0] if_rdata_reg;
    logic [DW-1:0] ls_rdata_reg;
    logic          idle;
    logic          any_req;

    assign idle    = (state_reg == ARB_IDLE);
    assign any_req = if_req_i | ls_req_i;

    cpu_mem_arbiter_prio_pick #(
        .STARVE_LIM (STARVE_LIM)
    ) u_prio_pick (
        .clk    (clk),
        .rest   (rest),
        .idle   (idle),
        .if_req (if_req_i),
        .ls_req (ls_req_i),
        .winner (winner)
    );

    // Memory data is only valid during RESP, so the rvalid cycle forwards it
    // directly; the register keeps it visible until the next response.
    assign if_rdata_o = if_rvalid_o ? mem_rdata_i : if_rdata_reg;
    assign ls_rdata_o = (ls_rvalid_o && !cmd_we_reg) ? mem_rdata_i : ls_rdata_reg;

    // The core must stall while anything is requested or an access is in flight.
    assign stall_o = any_req | !idle;

    // Access sequencer with registered memory command and handshake outputs.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_reg    <= ARB_IDLE;
            owner_reg    <= OWN_IF;
            cmd_we_reg   <= 1'b0;
            if_gnt_o     <= 1'b0;
            ls_gnt_o     <= 1'b0;
            if_rvalid_o  <= 1'b0;
            ls_rvalid_o  <= 1'b0;
            mem_en_o     <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_be_o     <= '0;
            if_rdata_reg <= '0;
            ls_rdata_reg <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if_rvalid_o <= 1'b0;
                    ls_rvalid_o <= 1'b0;
                    if (any_req) begin
                        owner_reg <= winner;
                        mem_en_o  <= 1'b1;
                        state_reg <= ARB_ISSUE;
                        if (winner == OWN_LS) begin
                            cmd_we_reg  <= ls_we_i;
                            mem_we_o    <= ls_we_i;
                            mem_addr_o  <= ls_addr_i;
                            mem_wdata_o <= ls_wdata_i;
                            mem_be_o    <= ls_be_i;
                            ls_gnt_o    <= 1'b1;
                        end else begin
                            // Fetches never write; wdata keeps its last value.
                            cmd_we_reg  <= 1'b0;
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= if_addr_i;
                            mem_be_o    <= '0;
                            if_gnt_o    <= 1'b1;
                        end
                    end
                end
                ARB_ISSUE: begin
                    mem_en_o    <= 1'b0;
                    mem_we_o    <= 1'b0;
                    if_gnt_o    <= 1'b0;
                    ls_gnt_o    <= 1'b0;
                    if_rvalid_o <= (owner_reg == OWN_IF);
                    ls_rvalid_o <= (owner_reg == OWN_LS);
                    state_reg   <= ARB_RESP;
                end
                ARB_RESP: begin
                    if_rvalid_o <= 1'b0;
                    ls_rvalid_o <= 1'b0;
                    if (owner_reg == OWN_IF) begin
                        if_rdata_reg <= mem_rdata_i;
                    end else if (!cmd_we_reg) begin
                        ls_rdata_reg <= mem_rdata_i;
                    end
                    state_reg <= ARB_IDLE;
                end
                default: begin
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    // A port is "waiting" when it requests but neither wins in IDLE this
    // cycle nor is in its gnt cycle (it lost arbitration or is blocked).
    logic if_accept;
    logic ls_accept;
    logic [31:0] if_wait_cnt_reg;
    logic [31:0] ls_wait_cnt_reg;

    assign if_accept     = idle && if_req_i && (winner == OWN_IF);
    assign ls_accept     = idle && ls_req_i && (winner == OWN_LS);
    assign if_wait_cnt_o = if_wait_cnt_reg;
    assign ls_wait_cnt_o = ls_wait_cnt_reg;

    // Free-running wait-cycle counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            if_wait_cnt_reg <= 32'd0;
            ls_wait_cnt_reg <= 32'd0;
        end else begin
            if (if_req_i && !if_accept && !if_gnt_o) begin
                if_wait_cnt_reg <= if_wait_cnt_reg + 32'd1;
            end
            if (ls_req_i && !ls_accept && !ls_gnt_o) begin
                ls_wait_cnt_reg <= ls_wait_cnt_reg + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed vector table, hand
// sequences for priority/starvation/reset, then randomized traffic checked
// against a transaction-level reference model with a shadow memory.
module tb_cpu_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rest;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          ls_req_i;
    logic          ls_we_i;
    logic [AW-1:0] ls_addr_i;
    logic [DW-1:0] ls_wdata_i;
    logic [3:0]    ls_be_i;
    logic          ls_gnt_o;
    logic          ls_rvalid_o;
    logic [DW-1:0] ls_rdata_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [3:0]    mem_be_o;
    logic [DW-1:0] mem_rdata = 32'h0;
    logic          stall_o;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   if_wait_cnt_o;
    logic [31:0]   ls_wait_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
        .clk         (clk),
        .rest        (rest),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .ls_req_i    (ls_req_i),
        .ls_we_i     (ls_we_i),
        .ls_addr_i   (ls_addr_i),
        .ls_wdata_i  (ls_wdata_i),
        .ls_be_i     (ls_be_i),
        .ls_gnt_o    (ls_gnt_o),
        .ls_rvalid_o (ls_rvalid_o),
        .ls_rdata_o  (ls_rdata_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_rdata_i (mem_rdata),
        .stall_o     (stall_o)
`ifdef ARB_PERF_CNT_EN
        ,
        .if_wait_cnt_o (if_wait_cnt_o),
        .ls_wait_cnt_o (ls_wait_cnt_o)
`endif
    );

    // Power-on contents of the 64-word memory.
    function automatic logic [31:0] mem_init(input int i);
        case (i)
            0:       return 32'h0000_0093;
            4:       return 32'hDEAD_BEEF;
            8:       return 32'hFFFF_FFFF;
            default: return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
        endcase
    endfunction

    // Single-port synchronous memory macro (read data one cycle after en).
    logic [31:0] tb_mem [0:63];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= mem_init(i);
            mem_ready <= 1'b1;
        end else if (mem_en_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) tb_mem[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
            mem_rdata <= tb_mem[mem_addr_o[7:2]];
        end
    end

    // Reference shadow memory.
    logic [31:0] shadow [0:63];

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) shadow[a[7:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        is_ls;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [0:7];

    // Random-phase model state.
    int          acc_age;
    int          starve;
    logic        acc_ls, acc_we;
    logic [31:0] acc_addr, acc_data, acc_wdata;
    logic [3:0]  acc_be;
    logic        if_gnt_exp, ls_gnt_exp;
    logic [31:0] last_if;
    logic        if_known;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_w0, ls_w0;
`endif

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,          4'hF, 4'h0, 32'h0000_0093};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          4'hF, 4'hF, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678,  4'h3, 4'h3, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,          4'hF, 4'hF, 32'hFFFF_5678};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0013, 32'h0,          4'h5, 4'h0, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0024, 32'hA5A5_A5A5,  4'hF, 4'hF, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0024, 32'h0,          4'hF, 4'h0, 32'hA5A5_A5A5};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0024, 32'h0,          4'h6, 4'h6, 32'hA5A5_A5A5};
        for (int i = 0; i < 64; i++) shadow[i] = mem_init(i);

        rest = 1'b0; if_req_i = 1'b0; if_addr_i = '0; ls_req_i = 1'b0; ls_we_i = 1'b0;
        ls_addr_i = '0; ls_wdata_i = '0; ls_be_i = '0;
        repeat (3) step();

        // Reset state.
        chk("rst gnt", {if_gnt_o, ls_gnt_o}, 0);
        chk("rst rvalid", {if_rvalid_o, ls_rvalid_o}, 0);
        chk("rst mem_en_we", {mem_en_o, mem_we_o}, 0);
        chk("rst mem_addr", mem_addr_o, 0);
        chk("rst mem_wdata", mem_wdata_o, 0);
        chk("rst mem_be", mem_be_o, 0);
        chk("rst if_rdata", if_rdata_o, 0);
        chk("rst ls_rdata", ls_rdata_o, 0);
        chk("rst stall", stall_o, 0);
        rest = 1'b1;

        // Directed single transactions; cycle 0 = request seen in IDLE.
        for (int v = 0; v < 8; v++) begin
            if_req_i = !vecs[v].is_ls; ls_req_i = vecs[v].is_ls;
            if_addr_i = vecs[v].addr; ls_addr_i = vecs[v].addr;
            ls_we_i = vecs[v].we; ls_wdata_i = vecs[v].wdata; ls_be_i = vecs[v].be;
            #1;
            chk($sformatf("v%0d c0 stall", v), stall_o, 1);
            step();
            chk($sformatf("v%0d c1 if_gnt", v), if_gnt_o, !vecs[v].is_ls);
            chk($sformatf("v%0d c1 ls_gnt", v), ls_gnt_o, vecs[v].is_ls);
            chk($sformatf("v%0d c1 mem_en", v), mem_en_o, 1);
            chk($sformatf("v%0d c1 mem_we", v), mem_we_o, vecs[v].is_ls & vecs[v].we);
            chk($sformatf("v%0d c1 mem_addr", v), mem_addr_o, vecs[v].addr);
            chk($sformatf("v%0d c1 mem_be", v), mem_be_o, vecs[v].exp_be);
            if (vecs[v].we) chk($sformatf("v%0d c1 mem_wdata", v), mem_wdata_o, vecs[v].wdata);
            if_req_i = 1'b0; ls_req_i = 1'b0;
            #1;
            chk($sformatf("v%0d c1 stall", v), stall_o, 1);
            step();
            chk($sformatf("v%0d c2 if_rvalid", v), if_rvalid_o, !vecs[v].is_ls);
            chk($sformatf("v%0d c2 ls_rvalid", v), ls_rvalid_o, vecs[v].is_ls);
            chk($sformatf("v%0d c2 mem_en_we", v), {mem_en_o, mem_we_o}, 0);
            chk($sformatf("v%0d c2 stall", v), stall_o, 1);
            if (!vecs[v].is_ls) chk($sformatf("v%0d c2 if_rdata", v), if_rdata_o, vecs[v].exp_rdata);
            else if (!vecs[v].we) chk($sformatf("v%0d c2 ls_rdata", v), ls_rdata_o, vecs[v].exp_rdata);
            if (vecs[v].is_ls && vecs[v].we) model_store(vecs[v].addr, vecs[v].wdata, vecs[v].be);
            step();
            chk($sformatf("v%0d c3 rvalid", v), {if_rvalid_o, ls_rvalid_o}, 0);
            chk($sformatf("v%0d c3 stall", v), stall_o, 0);
            if (!vecs[v].is_ls) chk($sformatf("v%0d c3 if_rdata hold", v), if_rdata_o, vecs[v].exp_rdata);
        end

        // Simultaneous requests: LS first, then IF.
`ifdef ARB_PERF_CNT_EN
        if_w0 = if_wait_cnt_o; ls_w0 = ls_wait_cnt_o;
`endif
        if_req_i = 1'b1; if_addr_i = 32'h0; ls_req_i = 1'b1; ls_we_i = 1'b0;
        ls_addr_i = 32'h10; ls_be_i = 4'hF;
        step();
        chk("both c1 ls_gnt", ls_gnt_o, 1);
        chk("both c1 if_gnt", if_gnt_o, 0);
        ls_req_i = 1'b0;
        step();
        chk("both c2 ls_rvalid", ls_rvalid_o, 1);
        chk("both c2 ls_rdata", ls_rdata_o, 32'hDEAD_BEEF);
        step();
        chk("both c3 if_gnt", if_gnt_o, 0);
        step();
        chk("both c4 if_gnt", if_gnt_o, 1);
        if_req_i = 1'b0;
        step();
        chk("both c5 if_rvalid", if_rvalid_o, 1);
        chk("both c5 if_rdata", if_rdata_o, 32'h0000_0093);
`ifdef ARB_PERF_CNT_EN
        chk("perf ls_wait", ls_wait_cnt_o - ls_w0, 0);
        chk("perf if_wait", if_wait_cnt_o - if_w0, 3);
`endif
        step();

        // Starvation: LS x4, IF, LS x4, IF with both held continuously.
        if_req_i = 1'b1; if_addr_i = 32'h0; ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h10;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("starve w%0d if_gnt", k), if_gnt_o, (k == 4 || k == 9));
            chk($sformatf("starve w%0d ls_gnt", k), ls_gnt_o, !(k == 4 || k == 9));
            step();
            step();
        end
        if_req_i = 1'b0; ls_req_i = 1'b0;
        step();

        // Reset while an IF read is in RESP: abandoned, outputs cleared at once.
        if_req_i = 1'b1; if_addr_i = 32'h0;
        step();
        chk("rstmid c1 if_gnt", if_gnt_o, 1);
        if_req_i = 1'b0;
        @(posedge clk);
        #1 rest = 1'b0;
        #1;
        chk("rstmid async rvalid", {if_rvalid_o, ls_rvalid_o}, 0);
        chk("rstmid async gnt_en", {if_gnt_o, ls_gnt_o, mem_en_o, mem_we_o}, 0);
        chk("rstmid async if_rdata", if_rdata_o, 0);
        chk("rstmid async mem_addr", mem_addr_o, 0);
        chk("rstmid async stall", stall_o, 0);
        step();
        chk("rstmid held rvalid", if_rvalid_o, 0);
        rest = 1'b1;
        if_req_i = 1'b1; if_addr_i = 32'h10;
        step();
        chk("rstmid new if_gnt", if_gnt_o, 1);
        if_req_i = 1'b0;
        step();
        chk("rstmid new if_rvalid", if_rvalid_o, 1);
        chk("rstmid new if_rdata", if_rdata_o, 32'hDEAD_BEEF);
        step();

        // Randomized traffic against the transaction-level model.
        acc_age = 3; starve = 0; acc_ls = 1'b0; acc_we = 1'b0;
        if_gnt_exp = 1'b0; ls_gnt_exp = 1'b0; if_known = 1'b0;
        for (int c = 0; c < 900; c++) begin
            if (!if_req_i || if_gnt_exp) begin
                if_req_i = ($urandom_range(0, 3) != 0);
                if_addr_i = 32'($urandom_range(0, 63)) << 2;
            end
            if (!ls_req_i || ls_gnt_exp) begin
                ls_req_i = ($urandom_range(0, 3) != 0);
                ls_we_i = 1'($urandom_range(0, 1));
                ls_addr_i = 32'($urandom_range(0, 63)) << 2;
                ls_wdata_i = $urandom;
                ls_be_i = 4'($urandom_range(0, 15));
            end
            #1;
            chk("rnd stall", stall_o, if_req_i | ls_req_i | (acc_age == 1 || acc_age == 2));
            if (acc_age >= 3) begin
                if (if_req_i || ls_req_i) begin
                    acc_ls = ls_req_i && !(if_req_i && starve == LIM);
                    if (!if_req_i || !acc_ls) starve = 0;
                    else if (starve < LIM) starve++;
                    acc_addr = acc_ls ? ls_addr_i : if_addr_i;
                    acc_we = acc_ls && ls_we_i;
                    acc_be = acc_ls ? ls_be_i : 4'h0;
                    acc_wdata = ls_wdata_i;
                    acc_data = shadow[acc_addr[7:2]];
                    if (acc_we) model_store(ls_addr_i, ls_wdata_i, ls_be_i);
                    acc_age = 0;
                end else begin
                    starve = 0;
                end
            end
            step();
            if (acc_age < 3) acc_age++;
            if_gnt_exp = (acc_age == 1) && !acc_ls;
            ls_gnt_exp = (acc_age == 1) && acc_ls;
            chk("rnd if_gnt", if_gnt_o, if_gnt_exp);
            chk("rnd ls_gnt", ls_gnt_o, ls_gnt_exp);
            chk("rnd mem_en", mem_en_o, acc_age == 1);
            chk("rnd mem_we", mem_we_o, (acc_age == 1) && acc_we);
            chk("rnd if_rvalid", if_rvalid_o, (acc_age == 2) && !acc_ls);
            chk("rnd ls_rvalid", ls_rvalid_o, (acc_age == 2) && acc_ls);
            if (acc_age == 1) begin
                chk("rnd mem_addr", mem_addr_o, acc_addr);
                chk("rnd mem_be", mem_be_o, acc_be);
                if (acc_we) chk("rnd mem_wdata", mem_wdata_o, acc_wdata);
            end
            if (acc_age == 2 && !acc_ls) begin
                chk("rnd if_rdata", if_rdata_o, acc_data);
                last_if = acc_data;
                if_known = 1'b1;
            end else if (if_known) begin
                chk("rnd if_rdata hold", if_rdata_o, last_if);
            end
            if (acc_age == 2 && acc_ls && !acc_we) chk("rnd ls_rdata", ls_rdata_o, acc_data);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
